// File: rtl/core_mc_seq.sv
// core_mc_seq: multi-cycle instruction sequencer (FETCH/EXEC/MEM/WB) with
// req/ack memory handshakes, wait timeout into a sticky error state,
// resumable halt and a retired-instruction counter.
module core_mc_seq #(
   parameter int unsigned IA_BITS  = 10,
   parameter int unsigned I_BITS   = 16,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned CNT_BITS = 32
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [IA_BITS-1:0]  imem_addr,
   input  logic                imem_ack,
   input  logic [I_BITS-1:0]   imem_rdata,
   output logic [I_BITS-1:0]   instr,
   output logic [IA_BITS-1:0]  pc,
   input  logic                dec_memRead,
   input  logic                dec_memWrite,
   input  logic                dec_regWrite,
   input  logic                dec_halt,
   input  logic [IA_BITS-1:0]  pc_next,
   output logic                dmem_req,
   output logic                dmem_we,
   input  logic                dmem_ack,
   output logic                reg_we,
   input  logic                resume,
   output logic                halted,
   output logic                err,
   output logic [CNT_BITS-1:0] retired
);

   localparam int unsigned W_BITS = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [W_BITS-1:0] W_LAST = W_BITS'(MAX_WAIT - 1);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_EXEC  = 3'd1,
      S_MEM   = 3'd2,
      S_WB    = 3'd3,
      S_HALT  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   state_t              state, state_nx;
   logic [W_BITS-1:0]   wait_cnt, wait_nx;
   logic [IA_BITS-1:0]  pc_nx;
   logic [CNT_BITS-1:0] ret_nx;
   logic [I_BITS-1:0]   ir_nx;

   // Fetch address is the PC register itself.
   assign imem_addr = pc;

   // Next-state, wait counter, PC, IR and retire-count computation.
   always_comb begin
      state_nx = state;
      wait_nx  = wait_cnt;
      pc_nx    = pc;
      ret_nx   = retired;
      ir_nx    = instr;
      case (state)
         S_FETCH: begin
            if (imem_ack) begin
               ir_nx    = imem_rdata;
               state_nx = S_EXEC;
            end else if (wait_cnt == W_LAST) begin
               state_nx = S_ERR;
            end else begin
               wait_nx = wait_cnt + W_BITS'(1);
            end
         end
         S_EXEC: begin
            if (dec_halt) begin
               state_nx = S_HALT;
               ret_nx   = retired + CNT_BITS'(1);
            end else if (dec_memRead || dec_memWrite) begin
               state_nx = S_MEM;
               wait_nx  = '0;
            end else begin
               state_nx = S_WB;
            end
         end
         S_MEM: begin
            if (dmem_ack) begin
               state_nx = S_WB;
            end else if (wait_cnt == W_LAST) begin
               state_nx = S_ERR;
            end else begin
               wait_nx = wait_cnt + W_BITS'(1);
            end
         end
         S_WB: begin
            pc_nx    = pc_next;
            ret_nx   = retired + CNT_BITS'(1);
            state_nx = S_FETCH;
            wait_nx  = '0;
         end
         S_HALT: begin
            if (resume) begin
               pc_nx    = pc + IA_BITS'(1);
               state_nx = S_FETCH;
               wait_nx  = '0;
            end
         end
         S_ERR: begin
            state_nx = S_ERR;
         end
         default: begin
            state_nx = S_ERR;
         end
      endcase
   end

   // State, datapath registers and registered outputs decoded from next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
         pc       <= IA_BITS'(RESET_PC);
         instr    <= '0;
         retired  <= '0;
         imem_req <= 1'b1;
         dmem_req <= 1'b0;
         dmem_we  <= 1'b0;
         reg_we   <= 1'b0;
         halted   <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         pc       <= pc_nx;
         instr    <= ir_nx;
         retired  <= ret_nx;
         imem_req <= (state_nx == S_FETCH);
         dmem_req <= (state_nx == S_MEM);
         dmem_we  <= (state_nx == S_MEM) && dec_memWrite;
         reg_we   <= (state_nx == S_WB) && dec_regWrite;
         halted   <= (state_nx == S_HALT);
         err      <= (state_nx == S_ERR);
      end
   end

endmodule
